// File: rtl/ch1_reg_port.sv
// ch1_reg_port
// CPU-side register port for square channel 1 (NR10..NR14 at FF10..FF14).
// Decodes CPU writes into the fields the channel 1 datapath consumes, merges
// the sweep unit's frequency write-back, and serves masked, registered CPU
// readback.
//
// Ports:
//   dova_phi     clock, all state updates on the rising edge
//   apu_reset    synchronous active-high reset
//   apu_wr/rd    one-cycle CPU write / read strobes
//   ff10..ff14   one-hot register selects
//   d            CPU write data
//   dout/dout_oe registered readback data and one-cycle drive enable
//   sweep_upd    sweep unit frequency write-back request
//   sweep_freq   write-back frequency
//   nch1_active  low while the channel is running
//   nr10         {period[2:0], negate, shift[2:0]}
//   duty         NR11 duty select
//   len_load     one-cycle length-counter load pulse, len_val valid with it
//   len_val      NR11 length-load value
//   nr12         envelope register
//   dac_en       DAC enable (nr12[7:3] != 0)
//   freq         11-bit channel frequency {NR14[2:0], NR13}
//   len_en       length-counter enable (NR14 bit 6)
//   ch1_restart  trigger pulse, RESTART_CYCLES clocks wide
//   ch1_kill     one-cycle pulse when the DAC is switched off mid-run
module ch1_reg_port #(
  parameter int RESTART_CYCLES = 4,
  parameter int LEN_BITS       = 6
) (
  input  logic                dova_phi,
  input  logic                apu_reset,
  input  logic                apu_wr,
  input  logic                apu_rd,
  input  logic                ff10,
  input  logic                ff11,
  input  logic                ff12,
  input  logic                ff13,
  input  logic                ff14,
  input  logic [7:0]          d,
  output logic [7:0]          dout,
  output logic                dout_oe,
  input  logic                sweep_upd,
  input  logic [10:0]         sweep_freq,
  input  logic                nch1_active,
  output logic [6:0]          nr10,
  output logic [1:0]          duty,
  output logic                len_load,
  output logic [LEN_BITS-1:0] len_val,
  output logic [7:0]          nr12,
  output logic                dac_en,
  output logic [10:0]         freq,
  output logic                len_en,
  output logic                ch1_restart,
  output logic                ch1_kill
);

  localparam int              RC_W    = $clog2(RESTART_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RESTART_CYCLES);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);

  // Masked readback: unused/write-only bits read as 1.
  function automatic logic [7:0] readback(
    input logic [4:0] sel,
    input logic [6:0] r10,
    input logic [1:0] r_duty,
    input logic [7:0] r12,
    input logic       r_len_en
  );
    logic [7:0] val;
    val = 8'h00;
    unique case (1'b1)
      sel[0]:  val = {1'b1, r10};
      sel[1]:  val = {r_duty, 6'b111111};
      sel[2]:  val = r12;
      sel[3]:  val = 8'hFF;
      sel[4]:  val = {1'b1, r_len_en, 6'b111111};
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  logic [4:0]      sel;
  logic            wr10, wr11, wr12, wr13, wr14;
  logic            trigger;
  logic            kill_next;
  logic            rd_vld_p0;
  logic [7:0]      rd_data_p0;
  logic [10:0]     freq_next;
  logic [RC_W-1:0] rc;
  logic [RC_W-1:0] rc_next;

  assign sel  = {ff14, ff13, ff12, ff11, ff10};
  assign wr10 = apu_wr & ff10;
  assign wr11 = apu_wr & ff11;
  assign wr12 = apu_wr & ff12;
  assign wr13 = apu_wr & ff13;
  assign wr14 = apu_wr & ff14;

  assign trigger   = wr14 & d[7];
  // Switching the DAC off while the channel runs must silence it at once.
  assign kill_next = wr12 & (d[7:3] == 5'd0) & ~nch1_active;

  assign ch1_restart = (rc != '0);
  assign dac_en      = |nr12[7:3];

  // Readback is sampled from pre-write state, so a same-cycle rd+wr to one
  // register returns the old value.
  assign rd_vld_p0  = apu_rd & (|sel);
  assign rd_data_p0 = readback(sel, nr10, duty, nr12, len_en);

  // Sweep write-back replaces the whole frequency, then a same-cycle CPU
  // write overrides only the byte it targets. Sweep is held off while the
  // restart pulse is active so the new trigger frequency is not clobbered.
  always_comb begin
    freq_next = freq;
    if (sweep_upd && !ch1_restart) freq_next = sweep_freq;
    if (wr13) freq_next[7:0] = d;
    if (wr14) freq_next[10:8] = d[2:0];
  end

  // A trigger (re)loads the counter, extending a pulse already in flight.
  always_comb begin
    rc_next = rc;
    if (rc != '0) rc_next = rc - RC_ONE;
    if (trigger) rc_next = RC_LOAD;
  end

  // Stage p0 -> p1: register state, pulses and readback
  always_ff @(posedge dova_phi) begin
    if (apu_reset) begin
      nr10     <= '0;
      duty     <= '0;
      len_val  <= '0;
      nr12     <= '0;
      freq     <= '0;
      len_en   <= 1'b0;
      len_load <= 1'b0;
      ch1_kill <= 1'b0;
      rc       <= '0;
      dout     <= 8'h00;
      dout_oe  <= 1'b0;
    end else begin
      if (wr10) nr10 <= d[6:0];
      if (wr11) begin
        duty    <= d[7:6];
        len_val <= LEN_BITS'(d[5:0]);
      end
      if (wr12) nr12 <= d;
      if (wr14) len_en <= d[6];
      freq     <= freq_next;
      len_load <= wr11;
      ch1_kill <= kill_next;
      rc       <= rc_next;
      dout_oe  <= rd_vld_p0;
      if (rd_vld_p0) dout <= rd_data_p0;
    end
  end

endmodule

// File: tb/tb_ch1_reg_port.sv
module tb_ch1_reg_port;

  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        rst, wr, rd;
  logic [4:0]  sel;
  logic [7:0]  d;
  logic        sweep_upd;
  logic [10:0] sweep_freq;
  logic        nact;

  logic [7:0]  dout;
  logic        dout_oe;
  logic [6:0]  nr10;
  logic [1:0]  duty;
  logic        len_load;
  logic [5:0]  len_val;
  logic [7:0]  nr12;
  logic        dac_en;
  logic [10:0] freq;
  logic        len_en;
  logic        ch1_restart;
  logic        ch1_kill;

  always #5 clk = ~clk;

  ch1_reg_port #(.RESTART_CYCLES(RC), .LEN_BITS(6)) dut (
    .dova_phi(clk), .apu_reset(rst), .apu_wr(wr), .apu_rd(rd),
    .ff10(sel[0]), .ff11(sel[1]), .ff12(sel[2]), .ff13(sel[3]), .ff14(sel[4]),
    .d(d), .dout(dout), .dout_oe(dout_oe),
    .sweep_upd(sweep_upd), .sweep_freq(sweep_freq), .nch1_active(nact),
    .nr10(nr10), .duty(duty), .len_load(len_load), .len_val(len_val),
    .nr12(nr12), .dac_en(dac_en), .freq(freq), .len_en(len_en),
    .ch1_restart(ch1_restart), .ch1_kill(ch1_kill)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst = 1'b0; wr = 1'b0; rd = 1'b0; sel = 5'h00; d = 8'h00;
    sweep_upd = 1'b0; sweep_freq = 11'h000; nact = 1'b1;
  endtask

  typedef struct {
    logic        wr, rd;
    logic [4:0]  sel;
    logic [7:0]  d;
    logic        su;
    logic [10:0] sf;
    logic        nact;
    logic [7:0]  e_dout;
    logic        e_oe;
    logic [10:0] e_freq;
    logic        e_rst, e_ll, e_kill, e_dac, e_le;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic w, input logic r, input logic [4:0] s, input logic [7:0] dd,
    input logic su, input logic [10:0] sf, input logic na,
    input logic [7:0] e_dout, input logic e_oe, input logic [10:0] e_freq,
    input logic e_rst, input logic e_ll, input logic e_kill, input logic e_dac,
    input logic e_le);
    vec_t v;
    v.wr = w; v.rd = r; v.sel = s; v.d = dd; v.su = su; v.sf = sf; v.nact = na;
    v.e_dout = e_dout; v.e_oe = e_oe; v.e_freq = e_freq; v.e_rst = e_rst;
    v.e_ll = e_ll; v.e_kill = e_kill; v.e_dac = e_dac; v.e_le = e_le;
    return v;
  endfunction

  // Behavioural model: register images plus the last cycle index at which
  // the restart pulse is still high.
  int          mcyc = 0;
  int          rend = -1000;
  logic [6:0]  m_nr10;
  logic [1:0]  m_duty;
  logic [5:0]  m_lv;
  logic [7:0]  m_nr12;
  logic [10:0] m_freq;
  logic        m_le, m_ll, m_kill, m_oe;
  logic [7:0]  m_dout;

  task automatic model_edge();
    logic       busy;
    logic [7:0] rb;
    busy = (mcyc <= rend);
    mcyc++;
    if (rst) begin
      m_nr10 = '0; m_duty = '0; m_lv = '0; m_nr12 = '0; m_freq = '0;
      m_le = 1'b0; m_ll = 1'b0; m_kill = 1'b0; m_oe = 1'b0; m_dout = 8'h00;
      rend = -1000;
    end else begin
      case (sel)
        5'h01:   rb = {1'b1, m_nr10};
        5'h02:   rb = {m_duty, 6'h3F};
        5'h04:   rb = m_nr12;
        5'h08:   rb = 8'hFF;
        5'h10:   rb = {1'b1, m_le, 6'h3F};
        default: rb = 8'h00;
      endcase
      m_oe = rd && (sel != 5'h00);
      if (m_oe) m_dout = rb;
      m_ll = 1'b0;
      m_kill = 1'b0;
      if (sweep_upd && !busy) m_freq = sweep_freq;
      if (wr) begin
        case (sel)
          5'h01: m_nr10 = d[6:0];
          5'h02: begin m_duty = d[7:6]; m_lv = d[5:0]; m_ll = 1'b1; end
          5'h04: begin
            m_nr12 = d;
            m_kill = (d[7:3] == 5'd0) && !nact;
          end
          5'h08: m_freq[7:0] = d;
          5'h10: begin
            m_freq[10:8] = d[2:0];
            m_le = d[6];
            if (d[7]) rend = mcyc + RC - 1;
          end
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    idle_in();

    // Reset held two cycles with a write that must be ignored.
    rst = 1'b1; wr = 1'b1; sel = 5'h01; d = 8'h7F;
    step();
    step();
    chk("rst_nr10", 16'(nr10), 16'h0);
    chk("rst_duty", 16'(duty), 16'h0);
    chk("rst_len_val", 16'(len_val), 16'h0);
    chk("rst_nr12", 16'(nr12), 16'h0);
    chk("rst_freq", 16'(freq), 16'h0);
    chk("rst_len_en", 16'(len_en), 16'h0);
    chk("rst_len_load", 16'(len_load), 16'h0);
    chk("rst_restart", 16'(ch1_restart), 16'h0);
    chk("rst_kill", 16'(ch1_kill), 16'h0);
    chk("rst_dout", 16'(dout), 16'h0);
    chk("rst_dout_oe", 16'(dout_oe), 16'h0);
    chk("rst_dac_en", 16'(dac_en), 16'h0);
    idle_in();

    //            wr    rd    sel    d      su    sf       na    dout   oe    freq     rst   ll    kill  dac   le
    tbl.push_back(mk(1'b1,1'b0,5'h01,8'h35,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h000,1'b0,1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,5'h02,8'h9A,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h000,1'b0,1'b1,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,5'h04,8'hF3,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h000,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'h01,8'h00,1'b0,11'h000,1'b1, 8'hB5,1'b1,11'h000,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'h02,8'h00,1'b0,11'h000,1'b1, 8'hBF,1'b1,11'h000,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'h04,8'h00,1'b0,11'h000,1'b1, 8'hF3,1'b1,11'h000,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'h08,8'h00,1'b0,11'h000,1'b1, 8'hFF,1'b1,11'h000,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'h00,8'h00,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h000,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,5'h08,8'h56,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h056,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,5'h10,8'hC5,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h556,1'b1,1'b0,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b0,1'b0,5'h00,8'h00,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h556,1'b1,1'b0,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b1,1'b0,5'h10,8'hC5,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h556,1'b1,1'b0,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b0,1'b0,5'h00,8'h00,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h556,1'b1,1'b0,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b0,1'b0,5'h00,8'h00,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h556,1'b1,1'b0,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b0,1'b0,5'h00,8'h00,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h556,1'b1,1'b0,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b0,1'b0,5'h00,8'h00,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h556,1'b0,1'b0,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b1,1'b0,5'h08,8'h23,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h523,1'b0,1'b0,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b1,1'b0,5'h10,8'h01,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h123,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,5'h08,8'h00,1'b1,11'h7AB,1'b1, 8'h00,1'b0,11'h700,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'h00,8'h00,1'b1,11'h7AB,1'b1, 8'h00,1'b0,11'h7AB,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,5'h10,8'h81,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h1AB,1'b1,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'h00,8'h00,1'b1,11'h345,1'b1, 8'h00,1'b0,11'h1AB,1'b1,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'h00,8'h00,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h1AB,1'b1,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'h00,8'h00,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h1AB,1'b1,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'h00,8'h00,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h1AB,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,5'h04,8'h07,1'b0,11'h000,1'b0, 8'h00,1'b0,11'h1AB,1'b0,1'b0,1'b1,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'h00,8'h00,1'b0,11'h000,1'b0, 8'h00,1'b0,11'h1AB,1'b0,1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,5'h04,8'h07,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h1AB,1'b0,1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,5'h04,8'hF3,1'b0,11'h000,1'b0, 8'h00,1'b0,11'h1AB,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b1,5'h04,8'h08,1'b0,11'h000,1'b1, 8'hF3,1'b1,11'h1AB,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'h10,8'h00,1'b0,11'h000,1'b1, 8'hBF,1'b1,11'h1AB,1'b0,1'b0,1'b0,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'h00,8'h00,1'b0,11'h000,1'b1, 8'h00,1'b0,11'h1AB,1'b0,1'b0,1'b0,1'b1,1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      wr = tbl[i].wr; rd = tbl[i].rd; sel = tbl[i].sel; d = tbl[i].d;
      sweep_upd = tbl[i].su; sweep_freq = tbl[i].sf; nact = tbl[i].nact;
      step();
      chk($sformatf("v%0d_dout_oe", i), 16'(dout_oe), 16'(tbl[i].e_oe));
      if (tbl[i].e_oe) chk($sformatf("v%0d_dout", i), 16'(dout), 16'(tbl[i].e_dout));
      chk($sformatf("v%0d_freq", i), 16'(freq), 16'(tbl[i].e_freq));
      chk($sformatf("v%0d_restart", i), 16'(ch1_restart), 16'(tbl[i].e_rst));
      chk($sformatf("v%0d_len_load", i), 16'(len_load), 16'(tbl[i].e_ll));
      if (tbl[i].e_ll) chk($sformatf("v%0d_len_val", i), 16'(len_val), 16'(tbl[i].d[5:0]));
      chk($sformatf("v%0d_kill", i), 16'(ch1_kill), 16'(tbl[i].e_kill));
      chk($sformatf("v%0d_dac_en", i), 16'(dac_en), 16'(tbl[i].e_dac));
      chk($sformatf("v%0d_len_en", i), 16'(len_en), 16'(tbl[i].e_le));
    end
    idle_in();

    // Reset landing on the second cycle of a restart pulse.
    wr = 1'b1; sel = 5'h10; d = 8'h87;
    step();
    idle_in();
    chk("mid_restart_c1", 16'(ch1_restart), 16'h1);
    chk("mid_freq_c1", 16'(freq), 16'h7AB);
    rst = 1'b1;
    step();
    chk("mid_restart_rst", 16'(ch1_restart), 16'h0);
    chk("mid_freq_rst", 16'(freq), 16'h0);
    rst = 1'b0;
    step();
    chk("mid_restart_after1", 16'(ch1_restart), 16'h0);
    step();
    chk("mid_restart_after2", 16'(ch1_restart), 16'h0);

    // Randomized run against the behavioural model, starting from reset.
    rst = 1'b1;
    model_edge();
    step();
    rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      int k;
      rst = ($urandom_range(0, 59) == 0);
      wr = 1'($urandom);
      rd = ($urandom_range(0, 2) == 0);
      k = $urandom_range(0, 5);
      sel = (k == 5) ? 5'h00 : 5'(1 << k);
      d = 8'($urandom);
      sweep_upd = ($urandom_range(0, 3) == 0);
      sweep_freq = 11'($urandom);
      nact = 1'($urandom);
      model_edge();
      step();
      chk("r_nr10", 16'(nr10), 16'(m_nr10));
      chk("r_duty", 16'(duty), 16'(m_duty));
      chk("r_nr12", 16'(nr12), 16'(m_nr12));
      chk("r_freq", 16'(freq), 16'(m_freq));
      chk("r_len_en", 16'(len_en), 16'(m_le));
      chk("r_len_load", 16'(len_load), 16'(m_ll));
      if (m_ll) chk("r_len_val", 16'(len_val), 16'(m_lv));
      chk("r_kill", 16'(ch1_kill), 16'(m_kill));
      chk("r_restart", 16'(ch1_restart), 16'(mcyc <= rend));
      chk("r_dac_en", 16'(dac_en), 16'(m_nr12[7:3] != 5'd0));
      chk("r_dout_oe", 16'(dout_oe), 16'(m_oe));
      if (m_oe) chk("r_dout", 16'(dout), 16'(m_dout));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
